// File: rtl/joypad_debounce.sv
// -----------------------------------------------------------------------------
// joypad_debounce
//
// Debounces the eight joypad button pins and presents them as an active-low
// vector for the FF00 joypad register block, plus a one-cycle interrupt
// request whenever any button becomes pressed.
//
// Each pin is first converted to active-low, then passed through a 2-flop
// synchronizer. A per-bit counter measures how many consecutive cycles the
// synchronized value has disagreed with the accepted (stable) value; once the
// disagreement has lasted DEBOUNCE_CYCLES cycles the new value is accepted.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to accept
//                    a change (1 .. 2**CNT_W-1)
//   CNT_W            width of each per-bit debounce counter
//   RAW_ACTIVE_HIGH  1: je_raw bit is 1 when pressed; 0: je_raw already low
//
// Ports
//   clk         in   system clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   je_raw[7:0] in   asynchronous button pins
//                    [3:0] right, left, up, down; [7:4] a, b, select, start
//   je[7:0]     out  debounced active-low buttons (0 = pressed), same order
//   joypad_irq  out  one-cycle pulse requesting the joypad interrupt
// -----------------------------------------------------------------------------
module joypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 16,
  parameter bit          RAW_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] je_raw,
  output logic [7:0] je,
  output logic       joypad_irq
);

  localparam int unsigned NUM_BTN = 8;

  // Counter value on the cycle that accepts a change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Active-low view of the raw pins, before synchronization.
  logic [7:0] raw_n;

  // Synchronizer stages; sync2_q is the synchronized value.
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  // Accepted button state (drives je) and its next value.
  logic [7:0] stable_q;
  logic [7:0] stable_d;

  // je as it was one edge earlier, used to spot 1->0 transitions.
  logic [7:0] je_prev_q;

  // Per-bit mismatch duration counters.
  logic [CNT_W-1:0] cnt_q [NUM_BTN];
  logic [CNT_W-1:0] cnt_d [NUM_BTN];

  logic irq_q;
  logic irq_d;

  assign raw_n = RAW_ACTIVE_HIGH ? ~je_raw : je_raw;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    stable_d = stable_q;
    for (int b = 0; b < NUM_BTN; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        // The synchronized value has now disagreed for DEBOUNCE_CYCLES
        // cycles: accept it and restart the counter. The >= keeps the
        // counter from ever running past the last value.
        if (cnt_q[b] >= CNT_LAST) begin
          stable_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end

    // A bit that was released on the previous edge's view and is pressed in
    // the current view fell on the last edge; the request follows one edge
    // later. Releases (0->1) never contribute.
    irq_d = |(je_prev_q & ~stable_q);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which keeps the synchronizer chain and
    // the je_prev_q history one cycle apart.
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '1;
      je_prev_q <= '1;
      irq_q     <= 1'b0;
      // NOTE: the counter array is a bank of individual flops, not a RAM,
      // so it is cleared on reset; stale partial counts must not survive.
      for (int b = 0; b < NUM_BTN; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q   <= raw_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      je_prev_q <= stable_q;
      irq_q     <= irq_d;
      for (int b = 0; b < NUM_BTN; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Outputs come straight from flops.
  assign je         = stable_q;
  assign joypad_irq = irq_q;

endmodule

// File: doc/joypad_debounce.md
JOYPAD_DEBOUNCE -- requirements
Module: joypad_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable synchronized cycles required to accept a change; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16: width of each per-bit debounce counter.
REQ-003 Parameter RAW_ACTIVE_HIGH, default 1: 1 means je_raw bit = 1 when pressed; 0 means je_raw is already active-low.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 je_raw  input  8  asynchronous button pins; [3:0] right, left, up, down; [7:4] a, b, select, start.
REQ-007 je  output  8  debounced, active-low (0 = pressed) button vector, same bit order; feeds the FF00 joypad register block.
REQ-008 joypad_irq  output  1  one-cycle pulse requesting the joypad interrupt (IF bit 4).

Function
REQ-009 Each bit shall be converted to active-low before synchronization: inverted when RAW_ACTIVE_HIGH=1, passed through when 0.
REQ-010 Each bit shall pass through a 2-flop synchronizer; the second-stage value is the sync bit.
REQ-011 Each bit shall hold a stable register (drives je) and a CNT_W-bit counter.
REQ-012 Sync bit equal to stable: counter shall load 0 that edge.
REQ-013 Sync bit differs from stable and counter < DEBOUNCE_CYCLES-1: counter shall increment by 1.
REQ-014 Sync bit differs from stable and counter == DEBOUNCE_CYCLES-1: stable shall take the sync value and counter shall load 0 that edge.
REQ-015 Counter shall never exceed DEBOUNCE_CYCLES-1 and shall never wrap.
REQ-016 A change on je_raw held constant shall appear on je exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling the new value.
REQ-017 Any mismatch interval shorter than DEBOUNCE_CYCLES synchronized cycles shall leave je unchanged and produce no irq.
REQ-018 The 8 bits shall be debounced independently; simultaneous changes on several bits shall be processed in parallel with no interaction.
REQ-019 joypad_irq shall be registered: high for exactly one cycle on the edge after any je bit transitions 1->0.
REQ-020 Multiple je bits falling on the same edge shall yield a single one-cycle irq pulse.
REQ-021 je bits falling on consecutive edges shall yield irq high on each corresponding following edge (no pulse merging logic).
REQ-022 je transitions 0->1 (release) shall not assert joypad_irq.
REQ-023 je and joypad_irq shall be driven directly from flops (no combinational path from je_raw).

Reset
REQ-024 On rst=1 at a rising edge: synchronizer flops = 1 (released), stable = 8'hFF, all counters = 0, joypad_irq = 0.
REQ-025 Reset asserted mid-count shall discard partial counts; after release a held press shall need the full 2+DEBOUNCE_CYCLES edges.
REQ-026 The first edge after reset deasserts shall not generate joypad_irq, even if buttons are held during reset.
REQ-027 rst shall take priority over every other update in the same cycle.

Verification (DEBOUNCE_CYCLES=4, RAW_ACTIVE_HIGH=1)
REQ-028 Reset: je_raw=8'h00, rst pulsed -> je=8'hFF, joypad_irq=0, steady for 20 cycles.
REQ-029 Press A: je_raw=8'h10 held -> je=8'hEF exactly 6 edges later, joypad_irq=1 for exactly the following cycle, 0 thereafter.
REQ-030 Bounce: je_raw[0]=1 for 3 cycles then 0 -> je stays 8'hFF, joypad_irq never asserted.
REQ-031 Simultaneous: je_raw 8'h00->8'h81 in one cycle -> je=8'h7E on one edge, single one-cycle irq pulse.
REQ-032 Release: from je=8'hEF, je_raw=8'h00 held -> je=8'hFF 6 edges later, joypad_irq stays 0.
REQ-033 Reset mid-count: je_raw=8'h02 held, rst pulsed 4 edges in -> je=8'hFF, then je=8'hFD exactly 6 edges after rst deasserts, one irq pulse.
